atm: RTL and testbench
======================

Name: atm

Overview:
- Single-clock ATM transaction controller holding a 10-account table: PIN and 16-bit balance per account.
- Each cycle it authenticates the presented account number and PIN, then executes the requested operation.
- Registers outputs: account balance, success flag and FSM state code.
- Sits between the keypad/card front-end and the display logic.

Parameters:
- NUM_ACCOUNTS, 10, number of account slots (account numbers 1..NUM_ACCOUNTS).
- INIT_BALANCE, 16'd1000, balance loaded into every account at reset.

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  asynchronous active-low reset
- operation  input  3  0=idle, 1=deposit, 2=withdraw, 3=balance inquiry, 4=change PIN, 5..7 reserved
- acc_num  input  4  account number, valid 1..10
- pin  input  16  entered PIN (binary value, e.g. 1234 decimal)
- newPin  input  16  replacement PIN for operation 4
- amount  input  16  deposit/withdraw amount, unsigned
- language  input  1  0=English, 1=Arabic; display-side tag only, no datapath effect
- balance  output  16  registered balance of the addressed account after the operation
- success  output  1  registered; 1 = last operation completed
- state  output  3  registered FSM state code

Behaviour:
- Reset (rst=0, asynchronous):
  - state=0 (IDLE), success=0, balance=0.
  - Every account balance = INIT_BALANCE.
  - PIN table restored: acc1=1234, 2=2345, 3=3456, 4=4567, 5=5678, 6=6789, 7=7890, 8=8901, 9=9012, 10=7123.
- Released reset: all inputs are sampled at each rising clk. Result appears one cycle later.
- Authentication: acc_num in 1..10 and pin equals the stored PIN of that account.
- State codes: 0 IDLE, 1 DEPOSIT, 2 WITHDRAW, 3 BALANCE, 4 CHANGE_PIN, 5 AUTH_FAIL.
- Transitions:
  - operation==0: state<=0, success<=0, balance holds.
  - operation 1..4 with failed authentication: state<=5, success<=0, balance<=0.
  - operation 5..7: state<=0, success<=0, balance holds, no table change.
  - operation 1..4 authenticated: state<=operation, actions below.
- Deposit (op 1):
  - If balance+amount <= 65535 (17-bit check): store the sum, output the new balance, success=1.
  - Else: no change, output the old balance, success=0.
- Withdraw (op 2):
  - If amount <= balance: store balance-amount, output it, success=1.
  - Else: no change, output the old balance, success=0.
  - amount==0 is legal; success=1.
- Balance inquiry (op 3): output the stored balance, success=1, no change.
- Change PIN (op 4):
  - Store PIN<=newPin, output balance, success=1.
  - Authentication from the next cycle uses the new PIN.
- Every cycle is independent; there is no session. Back-to-back different accounts are legal.
- Each cycle's result reflects updates from the prior cycle.
- Reset mid-sequence: the table and outputs return to reset values immediately.

Optional Feature:
- Macro ATM_LOCKOUT_EN.
- Defined:
  - Per-account 2-bit fail counter, incremented on each AUTH_FAIL with a matching valid acc_num.
  - At 3 the account is locked: all operations give state=5, success=0, even with the correct PIN.
  - A successful authentication before the lock clears the counter.
  - Only reset unlocks.
- Undefined: no counters; behaviour exactly as above.

Decomposition:
- Package atm_pkg:
  - op codes (OP_IDLE..OP_CHPIN).
  - state codes (ST_IDLE..ST_AUTH_FAIL).
  - NUM_ACCOUNTS.
  - default PIN constant array.
- One sub-module, atm_auth: combinational match of acc_num/pin against the PIN table.
  - Outputs auth_ok and account index.
  - Lockout gating when ATM_LOCKOUT_EN is defined.
- Table storage and FSM stay in atm.

Test Plan:
1. Reset held low with any inputs -> state=0, success=0, balance=0. After release, op=0 -> state stays 0.
2. op=3 on acc 1..10 with PINs 1234,2345,3456,4567,5678,6789,7890,8901,9012,7123, one per cycle -> each next cycle state=3, success=1, balance=1000.
3. acc 2 pin 2345: op=2 amount=300 -> state=2, balance=700, success=1. Then amount=800 -> balance=700, success=0.
4. acc 3 pin 3456: op=1 amount=65000 -> success=0, balance=1000. Then amount=500 -> balance=1500, success=1.
5. acc 4: op=4 pin=4567 newPin=1111 -> state=4, success=1. Then op=3 pin=4567 -> state=5, balance=0. Then op=3 pin=1111 -> state=3.
6. acc_num=0 or 11 with op=3 -> state=5, success=0.
   - With ATM_LOCKOUT_EN: three wrong PINs on acc 5, then the correct 5678 -> state=5.

Source files
------------

// File: rtl/atm_pkg.sv
// ============================================================================
// Module : atm_pkg
// Brief  : Shared op codes, FSM state codes and default PIN table for atm.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package atm_pkg;

    localparam int NUM_ACCOUNTS  = 10;
    localparam int PIN_TABLE_LEN = 10;

    localparam logic [2:0] OP_IDLE     = 3'd0;
    localparam logic [2:0] OP_DEPOSIT  = 3'd1;
    localparam logic [2:0] OP_WITHDRAW = 3'd2;
    localparam logic [2:0] OP_BALANCE  = 3'd3;
    localparam logic [2:0] OP_CHPIN    = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_DEPOSIT   = 3'd1,
        ST_WITHDRAW  = 3'd2,
        ST_BALANCE   = 3'd3,
        ST_CHPIN     = 3'd4,
        ST_AUTH_FAIL = 3'd5
    } state_t;

    // Element 0 belongs to account 1.
    localparam logic [PIN_TABLE_LEN-1:0][15:0] DEFAULT_PIN = {
        16'd7123, 16'd9012, 16'd8901, 16'd7890, 16'd6789,
        16'd5678, 16'd4567, 16'd3456, 16'd2345, 16'd1234
    };

    function automatic logic [15:0] default_pin(input int idx);
        return DEFAULT_PIN[4'(idx % PIN_TABLE_LEN)];
    endfunction

endpackage

`default_nettype wire

// File: rtl/atm_auth.sv
// ============================================================================
// Module : atm_auth
// Brief  : Combinational account/PIN match; lock gating under ATM_LOCKOUT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module atm_auth
    import atm_pkg::*;
#(
    parameter int NUM_ACCOUNTS = atm_pkg::NUM_ACCOUNTS
) (
    input  logic [3:0]                    acc_num,
    input  logic [15:0]                   pin,
    input  logic [NUM_ACCOUNTS-1:0][15:0] pin_table,
`ifdef ATM_LOCKOUT_EN
    input  logic [NUM_ACCOUNTS-1:0]       locked,
`endif
    output logic                          auth_ok,
    output logic                          acc_valid,
    output logic [3:0]                    acc_idx
);

    always_comb begin
        auth_ok   = 1'b0;
        acc_valid = 1'b0;
        acc_idx   = 4'd0;
        for (int i = 0; i < NUM_ACCOUNTS; i++) begin
            if (acc_num == 4'(i + 1)) begin
                acc_valid = 1'b1;
                acc_idx   = 4'(i);
`ifdef ATM_LOCKOUT_EN
                auth_ok   = (pin_table[i] == pin) && !locked[i];
`else
                auth_ok   = (pin_table[i] == pin);
`endif
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/atm.sv
// ============================================================================
// Module : atm
// Brief  : ATM transaction controller: account table, auth and op FSM.
//          Optional per-account lockout enabled by macro ATM_LOCKOUT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module atm
    import atm_pkg::*;
#(
    parameter int          NUM_ACCOUNTS = atm_pkg::NUM_ACCOUNTS,
    parameter logic [15:0] INIT_BALANCE = 16'd1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  operation,
    input  logic [3:0]  acc_num,
    input  logic [15:0] pin,
    input  logic [15:0] newPin,
    input  logic [15:0] amount,
    input  logic        language,
    output logic [15:0] balance,
    output logic        success,
    output logic [2:0]  state
);

    logic [NUM_ACCOUNTS-1:0][15:0] r_pin_tab;
    logic [15:0]                   r_bal [NUM_ACCOUNTS];
    state_t                        r_state;
    logic                          r_success;
    logic [15:0]                   r_balance;

    state_t      w_next_state;
    logic        w_next_success;
    logic [15:0] w_next_balance;
    logic        w_bal_we;
    logic [15:0] w_bal_wdata;
    logic        w_pin_we;
    logic        w_auth_ok;
    logic        w_acc_valid;
    logic [3:0]  w_idx;
    logic [15:0] w_cur_bal;
    logic [16:0] w_sum;
    logic        w_auth_op;

    // Language only tags the display path; nothing here depends on it.
    logic w_unused_language;
    assign w_unused_language = language;

`ifdef ATM_LOCKOUT_EN
    logic [1:0]              r_fail_cnt [NUM_ACCOUNTS];
    logic [NUM_ACCOUNTS-1:0] w_locked;

    always_comb begin
        w_locked = '0;
        for (int i = 0; i < NUM_ACCOUNTS; i++) begin
            w_locked[i] = (r_fail_cnt[i] == 2'd3);
        end
    end
`endif

    atm_auth #(
        .NUM_ACCOUNTS (NUM_ACCOUNTS)
    ) u_auth (
        .acc_num   (acc_num),
        .pin       (pin),
        .pin_table (r_pin_tab),
`ifdef ATM_LOCKOUT_EN
        .locked    (w_locked),
`endif
        .auth_ok   (w_auth_ok),
        .acc_valid (w_acc_valid),
        .acc_idx   (w_idx)
    );

    assign w_cur_bal = r_bal[w_idx];
    assign w_sum     = {1'b0, w_cur_bal} + {1'b0, amount};
    assign w_auth_op = (operation >= OP_DEPOSIT) && (operation <= OP_CHPIN);

    always_comb begin
        w_next_state   = ST_IDLE;
        w_next_success = 1'b0;
        w_next_balance = r_balance;
        w_bal_we       = 1'b0;
        w_bal_wdata    = w_cur_bal;
        w_pin_we       = 1'b0;
        if (w_auth_op && !w_auth_ok) begin
            w_next_state   = ST_AUTH_FAIL;
            w_next_balance = 16'd0;
        end else if (w_auth_op) begin
            w_next_balance = w_cur_bal;
            w_next_success = 1'b1;
            case (operation)
                OP_DEPOSIT: begin
                    w_next_state = ST_DEPOSIT;
                    if (!w_sum[16]) begin
                        w_bal_we       = 1'b1;
                        w_bal_wdata    = w_sum[15:0];
                        w_next_balance = w_sum[15:0];
                    end else begin
                        w_next_success = 1'b0;
                    end
                end
                OP_WITHDRAW: begin
                    w_next_state = ST_WITHDRAW;
                    if (amount <= w_cur_bal) begin
                        w_bal_we       = 1'b1;
                        w_bal_wdata    = w_cur_bal - amount;
                        w_next_balance = w_cur_bal - amount;
                    end else begin
                        w_next_success = 1'b0;
                    end
                end
                OP_BALANCE: w_next_state = ST_BALANCE;
                default: begin
                    w_next_state = ST_CHPIN;
                    w_pin_we     = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_success <= 1'b0;
            r_balance <= 16'd0;
        end else begin
            r_state   <= w_next_state;
            r_success <= w_next_success;
            r_balance <= w_next_balance;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_ACCOUNTS; i++) begin
                r_bal[i]     <= INIT_BALANCE;
                r_pin_tab[i] <= default_pin(i);
            end
        end else begin
            if (w_bal_we) begin
                r_bal[w_idx] <= w_bal_wdata;
            end
            if (w_pin_we) begin
                r_pin_tab[w_idx] <= newPin;
            end
        end
    end

`ifdef ATM_LOCKOUT_EN
    // Counter saturates at 3 (locked); only a pre-lock success clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_ACCOUNTS; i++) begin
                r_fail_cnt[i] <= 2'd0;
            end
        end else if (w_auth_op && w_acc_valid) begin
            if (w_auth_ok) begin
                r_fail_cnt[w_idx] <= 2'd0;
            end else if (r_fail_cnt[w_idx] != 2'd3) begin
                r_fail_cnt[w_idx] <= r_fail_cnt[w_idx] + 2'd1;
            end
        end
    end
`endif

    assign balance = r_balance;
    assign success = r_success;
    assign state   = r_state;

endmodule

`default_nettype wire

// File: tb/tb_atm.sv
// ============================================================================
// Module : tb_atm
// Brief  : Directed self-checking bench for atm (default and ATM_LOCKOUT_EN).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_atm;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  operation = 3'd0;
    logic [3:0]  acc_num = 4'd0;
    logic [15:0] pin = 16'd0;
    logic [15:0] newPin = 16'd0;
    logic [15:0] amount = 16'd0;
    logic        language = 1'b0;
    logic [15:0] balance;
    logic        success;
    logic [2:0]  state;

    int checks   = 0;
    int failures = 0;

    atm dut (
        .clk       (clk),
        .rst       (rst),
        .operation (operation),
        .acc_num   (acc_num),
        .pin       (pin),
        .newPin    (newPin),
        .amount    (amount),
        .language  (language),
        .balance   (balance),
        .success   (success),
        .state     (state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drive one request, let it be sampled, then sample the result #1 later.
    task automatic cyc(input logic [2:0] op, input logic [3:0] acc,
                       input logic [15:0] p, input logic [15:0] np,
                       input logic [15:0] amt);
        operation = op;
        acc_num   = acc;
        pin       = p;
        newPin    = np;
        amount    = amt;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        operation = 3'd1; acc_num = 4'd1; pin = 16'd1234; amount = 16'd55;
        @(posedge clk); @(posedge clk); #1;
        checks++;
        if ({state, success, balance} !== {3'd0, 1'b0, 16'd0}) begin
            $display("FAIL reset_hold: got st=%0d ok=%0b bal=%0d want st=0 ok=0 bal=0",
                     state, success, balance);
            failures++;
        end
        rst = 1'b1;
        cyc(3'd0, 4'd1, 16'd1234, 16'd0, 16'd0);
        checks++;
        if ({state, success, balance} !== {3'd0, 1'b0, 16'd0}) begin
            $display("FAIL reset_idle: got st=%0d ok=%0b bal=%0d want st=0 ok=0 bal=0",
                     state, success, balance);
            failures++;
        end
    endtask

    task automatic test_inquiry_all;
        logic [15:0] pins [10] = '{16'd1234, 16'd2345, 16'd3456, 16'd4567, 16'd5678,
                                   16'd6789, 16'd7890, 16'd8901, 16'd9012, 16'd7123};
        for (int i = 0; i < 10; i++) begin
            cyc(3'd3, 4'(i + 1), pins[i], 16'd0, 16'd0);
            checks++;
            if ({state, success, balance} !== {3'd3, 1'b1, 16'd1000}) begin
                $display("FAIL inquiry_acc%0d: got st=%0d ok=%0b bal=%0d want st=3 ok=1 bal=1000",
                         i + 1, state, success, balance);
                failures++;
            end
        end
    endtask

    task automatic test_withdraw;
        // acc 2: 1000 -300 =700; -800 refused; -700 =0; -0 ok; -1 refused
        logic [15:0] amt [5] = '{16'd300, 16'd800, 16'd700, 16'd0, 16'd1};
        logic [15:0] eb  [5] = '{16'd700, 16'd700, 16'd0, 16'd0, 16'd0};
        logic        eok [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            cyc(3'd2, 4'd2, 16'd2345, 16'd0, amt[i]);
            checks++;
            if ({state, success, balance} !== {3'd2, eok[i], eb[i]}) begin
                $display("FAIL withdraw_%0d: got st=%0d ok=%0b bal=%0d want st=2 ok=%0b bal=%0d",
                         i, state, success, balance, eok[i], eb[i]);
                failures++;
            end
        end
    endtask

    task automatic test_deposit;
        // acc 3: +65000 overflows; +500 =1500; +64035 =65535; +1 overflows
        logic [15:0] amt [4] = '{16'd65000, 16'd500, 16'd64035, 16'd1};
        logic [15:0] eb  [4] = '{16'd1000, 16'd1500, 16'd65535, 16'd65535};
        logic        eok [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            cyc(3'd1, 4'd3, 16'd3456, 16'd0, amt[i]);
            checks++;
            if ({state, success, balance} !== {3'd1, eok[i], eb[i]}) begin
                $display("FAIL deposit_%0d: got st=%0d ok=%0b bal=%0d want st=1 ok=%0b bal=%0d",
                         i, state, success, balance, eok[i], eb[i]);
                failures++;
            end
        end
    endtask

    task automatic test_change_pin;
        logic [15:0] p  [3] = '{16'd4567, 16'd4567, 16'd1111};
        logic [2:0]  op [3] = '{3'd4, 3'd3, 3'd3};
        logic [19:0] ex [3] = '{{3'd4, 1'b1, 16'd1000}, {3'd5, 1'b0, 16'd0},
                                {3'd3, 1'b1, 16'd1000}};
        for (int i = 0; i < 3; i++) begin
            cyc(op[i], 4'd4, p[i], 16'd1111, 16'd0);
            checks++;
            if ({state, success, balance} !== ex[i]) begin
                $display("FAIL chpin_%0d: got st/ok/bal=%h want %h",
                         i, {state, success, balance}, ex[i]);
                failures++;
            end
        end
    endtask

    task automatic test_invalid_acc;
        logic [3:0] acc [3] = '{4'd0, 4'd11, 4'd15};
        for (int i = 0; i < 3; i++) begin
            cyc(3'd3, acc[i], 16'd1234, 16'd0, 16'd0);
            checks++;
            if ({state, success, balance} !== {3'd5, 1'b0, 16'd0}) begin
                $display("FAIL invalid_acc%0d: got st=%0d ok=%0b bal=%0d want st=5 ok=0 bal=0",
                         acc[i], state, success, balance);
                failures++;
            end
        end
    endtask

    task automatic test_idle_reserved;
        cyc(3'd3, 4'd3, 16'd3456, 16'd0, 16'd0);   // loads 65535 onto output
        cyc(3'd0, 4'd1, 16'd1234, 16'd0, 16'd0);
        checks++;
        if ({state, success, balance} !== {3'd0, 1'b0, 16'd65535}) begin
            $display("FAIL idle_hold: got st=%0d ok=%0b bal=%0d want st=0 ok=0 bal=65535",
                     state, success, balance);
            failures++;
        end
        cyc(3'd7, 4'd1, 16'd1234, 16'd0, 16'd5);
        checks++;
        if ({state, success, balance} !== {3'd0, 1'b0, 16'd65535}) begin
            $display("FAIL reserved_op: got st=%0d ok=%0b bal=%0d want st=0 ok=0 bal=65535",
                     state, success, balance);
            failures++;
        end
        cyc(3'd3, 4'd1, 16'd1234, 16'd0, 16'd0);
        checks++;
        if ({state, success, balance} !== {3'd3, 1'b1, 16'd1000}) begin
            $display("FAIL reserved_no_change: got st=%0d ok=%0b bal=%0d want st=3 ok=1 bal=1000",
                     state, success, balance);
            failures++;
        end
    endtask

    task automatic test_back_to_back;
        logic [2:0]  op  [4] = '{3'd1, 3'd2, 3'd3, 3'd3};
        logic [3:0]  acc [4] = '{4'd1, 4'd1, 4'd6, 4'd1};
        logic [15:0] p   [4] = '{16'd1234, 16'd1234, 16'd6789, 16'd1234};
        logic [15:0] amt [4] = '{16'd100, 16'd50, 16'd0, 16'd0};
        logic [15:0] eb  [4] = '{16'd1100, 16'd1050, 16'd1000, 16'd1050};
        for (int i = 0; i < 4; i++) begin
            language = ~language;
            cyc(op[i], acc[i], p[i], 16'd0, amt[i]);
            checks++;
            if ({state, success, balance} !== {op[i], 1'b1, eb[i]}) begin
                $display("FAIL b2b_%0d: got st=%0d ok=%0b bal=%0d want st=%0d ok=1 bal=%0d",
                         i, state, success, balance, op[i], eb[i]);
                failures++;
            end
        end
    endtask

    task automatic test_lockout;
        logic [19:0] ex;
        for (int i = 0; i < 3; i++) begin
            cyc(3'd3, 4'd5, 16'd9999, 16'd0, 16'd0);
            checks++;
            if ({state, success, balance} !== {3'd5, 1'b0, 16'd0}) begin
                $display("FAIL wrong_pin_%0d: got st=%0d ok=%0b bal=%0d want st=5 ok=0 bal=0",
                         i, state, success, balance);
                failures++;
            end
        end
        cyc(3'd3, 4'd5, 16'd5678, 16'd0, 16'd0);
`ifdef ATM_LOCKOUT_EN
        ex = {3'd5, 1'b0, 16'd0};
`else
        ex = {3'd3, 1'b1, 16'd1000};
`endif
        checks++;
        if ({state, success, balance} !== ex) begin
            $display("FAIL after_3_fails: got st/ok/bal=%h want %h",
                     {state, success, balance}, ex);
            failures++;
        end
        // Two fails, success, two fails: never reaches 3 consecutive.
        cyc(3'd3, 4'd7, 16'd1, 16'd0, 16'd0);
        cyc(3'd3, 4'd7, 16'd1, 16'd0, 16'd0);
        cyc(3'd3, 4'd7, 16'd7890, 16'd0, 16'd0);
        cyc(3'd3, 4'd7, 16'd1, 16'd0, 16'd0);
        cyc(3'd3, 4'd7, 16'd1, 16'd0, 16'd0);
        cyc(3'd3, 4'd7, 16'd7890, 16'd0, 16'd0);
        checks++;
        if ({state, success, balance} !== {3'd3, 1'b1, 16'd1000}) begin
            $display("FAIL fail_cnt_clear: got st=%0d ok=%0b bal=%0d want st=3 ok=1 bal=1000",
                     state, success, balance);
            failures++;
        end
    endtask

    task automatic test_reset_mid;
        cyc(3'd2, 4'd2, 16'd2345, 16'd0, 16'd0);    // acc 2 holds 0
        cyc(3'd3, 4'd1, 16'd1234, 16'd0, 16'd0);    // output now 1050
        rst = 1'b0;
        #2;
        checks++;
        if ({state, success, balance} !== {3'd0, 1'b0, 16'd0}) begin
            $display("FAIL async_reset: got st=%0d ok=%0b bal=%0d want st=0 ok=0 bal=0",
                     state, success, balance);
            failures++;
        end
        @(posedge clk); #1;
        rst = 1'b1;
        cyc(3'd3, 4'd2, 16'd2345, 16'd0, 16'd0);
        checks++;
        if ({state, success, balance} !== {3'd3, 1'b1, 16'd1000}) begin
            $display("FAIL reset_bal_restore: got st=%0d ok=%0b bal=%0d want st=3 ok=1 bal=1000",
                     state, success, balance);
            failures++;
        end
        cyc(3'd3, 4'd4, 16'd4567, 16'd0, 16'd0);
        checks++;
        if ({state, success, balance} !== {3'd3, 1'b1, 16'd1000}) begin
            $display("FAIL reset_pin_restore: got st=%0d ok=%0b bal=%0d want st=3 ok=1 bal=1000",
                     state, success, balance);
            failures++;
        end
        cyc(3'd3, 4'd5, 16'd5678, 16'd0, 16'd0);
        checks++;
        if ({state, success, balance} !== {3'd3, 1'b1, 16'd1000}) begin
            $display("FAIL reset_unlock: got st=%0d ok=%0b bal=%0d want st=3 ok=1 bal=1000",
                     state, success, balance);
            failures++;
        end
    endtask

    initial begin
        test_reset;
        test_inquiry_all;
        test_withdraw;
        test_deposit;
        test_change_pin;
        test_invalid_acc;
        test_idle_reserved;
        test_back_to_back;
        test_lockout;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
